// File: rtl/pulse_period_meter.sv
// pulse_period_meter: measures period, high time and duty of a pulse train.
// Ports: sysclk/reset/Pulse_in/Clear in; Period/High_time/Duty/Meas_valid/Timeout/Busy out.
module pulse_period_meter #(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DUTY_W      = 8,
  parameter int TIMEOUT     = 50_000_000
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              Pulse_in,
  input  logic              Clear,
  output logic [CNT_W-1:0]  Period,
  output logic [CNT_W-1:0]  High_time,
  output logic [DUTY_W-1:0] Duty,
  output logic              Meas_valid,
  output logic              Timeout,
  output logic              Busy
);

  localparam logic [1:0] S_WAIT = 2'd0;
  localparam logic [1:0] S_MEAS = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int BIT_W = $clog2(DUTY_W + 1);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_prev_q, s_prev_d;
  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       idle_q, idle_d;
  logic [CNT_W-1:0]       per_q, per_d;
  logic [CNT_W-1:0]       hi_q, hi_d;
  logic [CNT_W-1:0]       p_q, p_d;
  logic [CNT_W-1:0]       h_q, h_d;
  logic [CNT_W-1:0]       rem_q, rem_d;
  logic [DUTY_W-1:0]      quo_q, quo_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic [CNT_W-1:0]       high_q, high_d;
  logic [DUTY_W-1:0]      duty_q, duty_d;
  logic                   valid_q, valid_d;
  logic                   tmo_q, tmo_d;

  logic              s;
  logic              rise;
  logic [CNT_W:0]    rem_shl;
  logic [CNT_W:0]    rem_sub;
  logic              ge;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_prev_q;

  // Remainder stays below P, so CNT_W bits hold it between steps.
  assign rem_shl = {rem_q, 1'b0};
  assign ge      = rem_shl >= {1'b0, p_q};
  assign rem_sub = rem_shl - {1'b0, p_q};

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], Pulse_in};
    s_prev_d = s;
    state_d  = state_q;
    idle_d   = idle_q;
    per_d    = per_q;
    hi_d     = hi_q;
    p_d      = p_q;
    h_d      = h_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    bit_d    = bit_q;
    period_d = period_q;
    high_d   = high_q;
    duty_d   = duty_q;
    valid_d  = 1'b0;
    tmo_d    = tmo_q;

    if (Clear) begin
      state_d = S_WAIT;
      idle_d  = '0;
      per_d   = '0;
      hi_d    = '0;
      p_d     = '0;
      h_d     = '0;
      rem_d   = '0;
      quo_d   = '0;
      bit_d   = '0;
    end else begin
      unique case (state_q)
        S_WAIT: begin
          // Terminal count beats a coincident rise.
          if (idle_q == TMO) begin
            tmo_d    = 1'b1;
            period_d = '0;
            high_d   = '0;
            duty_d   = '0;
            idle_d   = '0;
          end else if (rise) begin
            state_d = S_MEAS;
            per_d   = ONE;
            hi_d    = ONE;
            idle_d  = '0;
          end else begin
            idle_d = idle_q + ONE;
          end
        end
        S_MEAS: begin
          if (per_q == TMO) begin
            tmo_d    = 1'b1;
            period_d = '0;
            high_d   = '0;
            duty_d   = '0;
            per_d    = '0;
            hi_d     = '0;
            idle_d   = '0;
            state_d  = S_WAIT;
          end else if (rise) begin
            p_d     = per_q;
            h_d     = hi_q;
            rem_d   = hi_q;
            quo_d   = '0;
            bit_d   = '0;
            per_d   = '0;
            hi_d    = '0;
            state_d = S_DIV;
          end else begin
            per_d = per_q + ONE;
            if (s) begin
              hi_d = hi_q + ONE;
            end
          end
        end
        S_DIV: begin
          rem_d = ge ? CNT_W'(rem_sub) : CNT_W'(rem_shl);
          quo_d = DUTY_W'({quo_q, ge});
          bit_d = bit_q + BIT_W'(1);
          if (bit_q == BIT_W'(DUTY_W - 1)) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          period_d = p_q;
          high_d   = h_q;
          // H >= P overflows the quotient register.
          duty_d   = (h_q >= p_q) ? '1 : quo_q;
          valid_d  = 1'b1;
          tmo_d    = 1'b0;
          idle_d   = '0;
          state_d  = S_WAIT;
        end
      endcase
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      sync_q   <= '0;
      s_prev_q <= 1'b0;
      state_q  <= S_WAIT;
      idle_q   <= '0;
      per_q    <= '0;
      hi_q     <= '0;
      p_q      <= '0;
      h_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      bit_q    <= '0;
      period_q <= '0;
      high_q   <= '0;
      duty_q   <= '0;
      valid_q  <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      s_prev_q <= s_prev_d;
      state_q  <= state_d;
      idle_q   <= idle_d;
      per_q    <= per_d;
      hi_q     <= hi_d;
      p_q      <= p_d;
      h_q      <= h_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      bit_q    <= bit_d;
      period_q <= period_d;
      high_q   <= high_d;
      duty_q   <= duty_d;
      valid_q  <= valid_d;
      tmo_q    <= tmo_d;
    end
  end

  assign Period     = period_q;
  assign High_time  = high_q;
  assign Duty       = duty_q;
  assign Meas_valid = valid_q;
  assign Timeout    = tmo_q;
  assign Busy       = (state_q == S_MEAS) | (state_q == S_DIV);

endmodule
